// File: rtl/dcache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_refill_ctrl
// Purpose  : Data-cache miss/refill and write-through sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_refill_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic                  hit_i,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  fill_we_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  tag_we_o
);

    localparam int                    c_CNT_W     = $clog2(WORDS_PER_LINE);
    localparam logic [ADDR_WIDTH-1:0] c_LINE_MASK = ~ADDR_WIDTH'(WORDS_PER_LINE * 4 - 1);
    localparam logic [ADDR_WIDTH-1:0] c_WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [c_CNT_W-1:0]    c_CNT_LAST  = c_CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_RF_REQ  = 3'd2,
        S_RF_WAIT = 3'd3,
        S_RF_DONE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                r_state_q,     w_state_d;
    logic [c_CNT_W-1:0]    r_cnt_q,       w_cnt_d;
    logic [ADDR_WIDTH-1:0] r_base_q,      w_base_d;
    logic                  r_mem_req_q,   w_mem_req_d;
    logic                  r_mem_we_q,    w_mem_we_d;
    logic [ADDR_WIDTH-1:0] r_mem_addr_q,  w_mem_addr_d;
    logic [DATA_WIDTH-1:0] r_mem_wdata_q, w_mem_wdata_d;
    logic                  r_fill_we_q,   w_fill_we_d;
    logic [ADDR_WIDTH-1:0] r_fill_addr_q, w_fill_addr_d;
    logic [DATA_WIDTH-1:0] r_fill_data_q, w_fill_data_d;
    logic                  r_tag_we_q,    w_tag_we_d;
    logic                  w_stall;

    // Line base keeps its offset bits zero, so OR-ing in the word index is an add.
    function automatic logic [ADDR_WIDTH-1:0] f_word_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [c_CNT_W-1:0]    idx
    );
        return base | (ADDR_WIDTH'(idx) << 2);
    endfunction

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_base_d      = r_base_q;
        w_mem_req_d   = r_mem_req_q;
        w_mem_we_d    = r_mem_we_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;
        w_fill_we_d   = 1'b0;
        w_fill_addr_d = r_fill_addr_q;
        w_fill_data_d = r_fill_data_q;
        w_tag_we_d    = 1'b0;
        w_stall       = 1'b1;

        case (r_state_q)
            S_IDLE: begin
                w_stall = req_valid_i & (req_we_i | ~hit_i);
                w_cnt_d = '0;
                if (req_valid_i && req_we_i) begin
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = 1'b1;
                    w_mem_addr_d  = req_addr_i & c_WORD_MASK;
                    w_mem_wdata_d = req_wdata_i;
                    w_state_d     = S_WR_REQ;
                end else if (req_valid_i && !hit_i) begin
                    w_base_d     = req_addr_i & c_LINE_MASK;
                    w_mem_req_d  = 1'b1;
                    w_mem_we_d   = 1'b0;
                    w_mem_addr_d = req_addr_i & c_LINE_MASK;
                    w_state_d    = S_RF_REQ;
                end
            end
            S_WR_REQ: begin
                if (mem_gnt_i) begin
                    w_mem_req_d = 1'b0;
                    w_mem_we_d  = 1'b0;
                    w_state_d   = S_DONE;
                end
            end
            S_RF_REQ: begin
                if (mem_gnt_i) begin
                    w_mem_req_d = 1'b0;
                    w_state_d   = S_RF_WAIT;
                end
            end
            S_RF_WAIT: begin
                if (mem_rvalid_i) begin
                    w_fill_we_d   = 1'b1;
                    w_fill_addr_d = f_word_addr(r_base_q, r_cnt_q);
                    w_fill_data_d = mem_rdata_i;
                    if (r_cnt_q == c_CNT_LAST) begin
                        w_state_d = S_RF_DONE;
                    end else begin
                        w_cnt_d      = r_cnt_q + c_CNT_W'(1);
                        w_mem_req_d  = 1'b1;
                        w_mem_addr_d = f_word_addr(r_base_q, r_cnt_q + c_CNT_W'(1));
                        w_state_d    = S_RF_REQ;
                    end
                end
            end
            S_RF_DONE: begin
                w_tag_we_d    = 1'b1;
                w_fill_addr_d = r_base_q;
                w_state_d     = S_DONE;
            end
            S_DONE: begin
                // One unstalled cycle lets the held instruction retire.
                w_stall   = 1'b0;
                w_state_d = S_IDLE;
            end
            default: begin
                w_stall   = 1'b0;
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= S_IDLE;
            r_cnt_q       <= '0;
            r_base_q      <= '0;
            r_mem_req_q   <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
            r_fill_we_q   <= 1'b0;
            r_fill_addr_q <= '0;
            r_fill_data_q <= '0;
            r_tag_we_q    <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_base_q      <= w_base_d;
            r_mem_req_q   <= w_mem_req_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
            r_fill_we_q   <= w_fill_we_d;
            r_fill_addr_q <= w_fill_addr_d;
            r_fill_data_q <= w_fill_data_d;
            r_tag_we_q    <= w_tag_we_d;
        end
    end

    assign stall_o     = rst_n & w_stall;
    assign mem_req_o   = r_mem_req_q;
    assign mem_we_o    = r_mem_we_q;
    assign mem_addr_o  = r_mem_addr_q;
    assign mem_wdata_o = r_mem_wdata_q;
    assign fill_we_o   = r_fill_we_q;
    assign fill_addr_o = r_fill_addr_q;
    assign fill_data_o = r_fill_data_q;
    assign tag_we_o    = r_tag_we_q;

endmodule
`default_nettype wire

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
- Miss/refill and write-through sequencer for the memory-stage data cache.
- Watches each memory-stage access, stalls the pipeline on a load miss or any store, and refills a full line from backing memory over a request/grant/response handshake.
- Drives the cache's fill port and tag-write strobe.
- Sits between the memory stage, the hazard unit (`stall_o`) and the backing-memory port.

Parameters:
- WORDS_PER_LINE, 4, 32-bit words per cache line; power of two, ≥2.
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data word width.

Ports:
- clk  in  1  system clock; single clock domain, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid_i  in  1  memory-stage access valid (load or store).
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_WIDTH  byte address of access.
- req_wdata_i  in  DATA_WIDTH  store data.
- hit_i  in  1  cache tag-compare hit, same cycle as request.
- stall_o  out  1  freeze pipeline; combinational.
- mem_req_o  out  1  backing-memory request valid.
- mem_we_o  out  1  request is a write.
- mem_addr_o  out  ADDR_WIDTH  request byte address, word aligned.
- mem_wdata_o  out  DATA_WIDTH  write data.
- mem_gnt_i  in  1  request accepted this cycle (`mem_req_o` & `mem_gnt_i`).
- mem_rvalid_i  in  1  read response valid.
- mem_rdata_i  in  DATA_WIDTH  read response data.
- fill_we_o  out  1  write one refill word into the cache data array.
- fill_addr_o  out  ADDR_WIDTH  byte address of the refill word.
- fill_data_o  out  DATA_WIDTH  refill word.
- tag_we_o  out  1  one-cycle pulse: set tag+valid for `fill_addr_o`'s line.

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE; word counter to 0.
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `fill_we_o`, `fill_addr_o`, `fill_data_o`, `tag_we_o` all go to 0 immediately.
  - `stall_o` is 0 while in reset.
- All `mem_*` and `fill_*`/`tag_*` outputs are registered. `stall_o` is combinational.
- Line base = `req_addr_i` with the low log2(WORDS_PER_LINE*4) bits cleared. It is latched on the miss cycle.
- IDLE:
  - `stall_o` = `req_valid_i` & (`req_we_i` | ~`hit_i`).
  - Load hit: no action, `stall_o`=0.
  - Store: latch address (bits[1:0] cleared) and data → WR_REQ. Stores are write-through, no write-allocate; a store hit is updated by the cache itself.
  - Load miss: latch line base, counter=0 → RF_REQ.
- WR_REQ:
  - `stall_o`=1; `mem_req_o`=1, `mem_we_o`=1; address and data held stable until grant.
  - On `mem_gnt_i`: drop request next cycle → DONE. Writes are posted; no response is expected.
- RF_REQ:
  - `stall_o`=1; `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o` = base + 4·counter, held stable until grant.
  - On `mem_gnt_i` → RF_WAIT, request deasserted.
  - At most one outstanding read.
- RF_WAIT:
  - `stall_o`=1.
  - On `mem_rvalid_i`: next cycle `fill_we_o`=1 (one-cycle pulse), `fill_addr_o` = base + 4·counter, `fill_data_o` = `mem_rdata_i`.
  - Then: if counter = WORDS_PER_LINE−1 → RF_DONE; else counter+1 → RF_REQ.
- RF_DONE:
  - `stall_o`=1; `tag_we_o`=1 for exactly one cycle with `fill_addr_o` = line base → DONE.
- DONE:
  - `stall_o`=0 for exactly one cycle, so the stalled instruction retires (a load now hits). `req_valid_i` is ignored in this cycle.
  - → IDLE.
- Boundary conditions:
  - `mem_rvalid_i` outside RF_WAIT: ignored, no fill.
  - `mem_gnt_i` without `mem_req_o`: ignored.
  - `mem_gnt_i` held permanently high: still one request per response.
  - Grant and response in the same cycle are impossible; response earliest the cycle after grant.
  - Counter wraps only via reset or IDLE re-entry; no line crossing.
  - Reset mid-refill: `tag_we_o` is never pulsed, so the partially filled line stays invalid; the next access to it performs a full refill.
  - Latched address/data are unaffected by input changes while not in IDLE.

Test Plan:
1. Load hit (`req_valid`=1, `we`=0, `hit`=1, addr 0x40) → `stall_o`=0 same cycle; `mem_req_o` stays 0 for 10 cycles.
2. Load miss addr 0x0000_1234, grant immediate, rvalid 2 cycles after each grant, rdata 0xA0..0xA3:
   - `mem_addr_o` sequence 0x1230, 0x1234, 0x1238, 0x123C.
   - Four `fill_we_o` pulses with matching addr/data.
   - One `tag_we_o` pulse at 0x1230.
   - `stall_o`=1 throughout, then exactly one cycle of `stall_o`=0.
3. Store addr 0x100, data 0xDEADBEEF, grant delayed 3 cycles → `mem_req_o`/`mem_we_o`=1 with stable 0x100/0xDEADBEEF for 4 cycles; `stall_o`=1 until the DONE cycle; no fill or tag writes.
4. `rst_n` pulled low after the 2nd fill word of a miss at 0x2000 → all outputs 0 asynchronously, `tag_we_o` never asserted. A repeat load at 0x2000 after reset performs a full 4-word refill starting at 0x2000.
5. Load miss followed immediately by a store, with `req_valid` held high → request ignored in the DONE cycle; the store enters WR_REQ on the following IDLE cycle.
6. Spurious `mem_rvalid_i` in IDLE and in RF_REQ, plus `mem_gnt_i` tied to 1 → no `fill_we_o` from the spurious responses; exactly one `mem_req_o` per received response; fill count is exactly 4.
